reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 5'h0, CSR base address; the block occupies BASE_ADDR (DELAY) and BASE_ADDR+1 (CTRL).
REQ-002 Parameter NUM_STAGES, default 4, number of sequenced reset outputs; legal range 1..4.
REQ-003 Parameter DFL_DELAY, default 8'd4, reset value of the DELAY register, in ce ticks.
REQ-004 clk  input  1  single system clock; every flop is clocked by clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ce  input  1  single-cycle clock-enable tick that paces the stage delay.
REQ-007 start  input  1  single-cycle pulse that begins or restarts the sequence.
REQ-008 abort  input  1  single-cycle pulse that re-asserts all resets and returns to IDLE.
REQ-009 hold  input  NUM_STAGES  per-stage level that keeps the stage in reset (board config).
REQ-010 csr_a  input  5  CSR address.
REQ-011 csr_di  input  8  CSR write data.
REQ-012 csr_we  input  1  CSR write strobe, valid for one cycle.
REQ-013 csr_do  output  8  CSR read data; 8'h00 when csr_a matches neither register, so it can be OR-combined on the shared bus.
REQ-014 rst_out  output  NUM_STAGES  active-high, registered reset per stage.
REQ-015 done  output  1  registered; high while in DONE.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and DONE, plus a stage index idx of width 2 and an 8-bit tick counter cnt.
REQ-017 In IDLE, every released flag SHALL be 0; start SHALL load cnt with DELAY, set idx to 0 and enter WAIT.
REQ-018 In WAIT, a ce with cnt != 0 SHALL decrement cnt.
REQ-019 In WAIT, a ce with cnt == 0 SHALL set released[idx]; if idx == NUM_STAGES-1 the FSM SHALL enter DONE, otherwise idx increments and cnt reloads with DELAY.
REQ-020 With DELAY == 0, each stage SHALL release on the first ce after entering that stage.
REQ-021 With DELAY == N, each stage SHALL release on the (N+1)th ce after entering that stage.
REQ-022 rst_out[k] SHALL be registered as !released[k] | hold[k] | sw_force[k], so it changes one clk after the condition changes.
REQ-023 hold and sw_force SHALL mask the output only and SHALL NOT stall the sequence.
REQ-024 A start in WAIT or DONE SHALL clear all released flags, set idx to 0, reload cnt and enter WAIT in the same cycle (restart).
REQ-025 abort SHALL clear all released flags and enter IDLE; abort SHALL win over a simultaneous start or ce.
REQ-026 A ce coinciding with start SHALL NOT count toward the new stage.
REQ-027 The DELAY register (BASE_ADDR) SHALL be 8-bit read/write; a write SHALL take effect at the next cnt reload, and an in-flight count SHALL NOT be altered.
REQ-028 CTRL (BASE_ADDR+1) bits [NUM_STAGES-1:0] SHALL be sw_force (R/W); unused bits in [3:0] SHALL read 0.
REQ-029 CTRL bits [5:4] SHALL read idx, bit 6 SHALL read busy (state == WAIT), and bit 7 SHALL read done; writes to bits [7:4] SHALL be ignored.
REQ-030 CSR reads SHALL be combinational from csr_a.

Reset
REQ-031 While rst_n is low: state = IDLE, idx = 0, cnt = 0, released = 0, DELAY = DFL_DELAY, sw_force = 0, rst_out = all ones, done = 0.
REQ-032 Reset asserted mid-sequence SHALL re-assert all rst_out immediately and asynchronously; no stage SHALL release until a new start arrives after reset.

Structure
REQ-033 State encodings and the register offsets DELAY = 0 and CTRL = 1 SHALL live in a shared package, sl28_pkg.
REQ-034 The tick counter SHALL be a single sub-module, tick_counter (load, ce, zero flag); all other logic SHALL stay flat.

Verification
REQ-035 DELAY = 2, start, ce every 4 clk -> rst_out goes 1111->1110->1100->1000->0000, each step 3 ce apart; done = 1 after the last step; CTRL reads 8'h80.
REQ-036 hold = 4'b0100, full sequence -> final rst_out = 4'b0100; done = 1.
REQ-037 Start in WAIT at idx = 2 -> rst_out = 1111 one clk later; sequence restarts at idx 0; CTRL bit 6 = 1.
REQ-038 abort and start in the same cycle -> FSM in IDLE, rst_out = 1111, CTRL reads 8'h00.
REQ-039 rst_n pulled low at idx = 1 -> rst_out = 1111 without a clk edge; DELAY reads DFL_DELAY afterwards.
REQ-040 DELAY = 0, write CTRL = 8'hFF -> CTRL reads 8'h0F before start; rst_out stays 1111 through the sequence; csr_a = BASE_ADDR+2 reads 8'h00.

Source files
------------

// File: rtl/sl28_pkg.sv
// sl28_pkg: shared constants for the reset sequencer.
//   - FSM state encodings (IDLE, WAIT, DONE)
//   - CSR register offsets relative to the block base address
package sl28_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] OFF_DELAY = 5'd0;
    localparam logic [4:0] OFF_CTRL  = 5'd1;

endpackage

// File: rtl/reset_sequencer_tick_counter.sv
// tick_counter: 8-bit down-counter paced by a clock-enable tick.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset (count clears to 0)
//   load_i  load val_i into the count; wins over ce_i
//   val_i   reload value
//   ce_i    decrement request; ignored once the count reaches 0
//   zero_o  high while the count is 0
module tick_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] val_i,
    input  logic       ce_i,
    output logic       zero_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (ce_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset outputs one after another,
// each stage waiting DELAY+1 ce ticks, with CSR control.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ce                pacing tick for the stage delay
//   start             begin / restart the sequence
//   abort             re-assert all resets and return to IDLE
//   hold              per-stage level mask keeping a stage in reset
//   csr_a/di/we       CSR address, write data, write strobe
//   csr_do            CSR read data (8'h00 when not addressed)
//   rst_out           registered active-high reset per stage
//   done              registered, high while the sequence is complete
module reset_sequencer
    import sl28_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR  = 5'h0,
    parameter int         NUM_STAGES = 4,
    parameter logic [7:0] DFL_DELAY  = 8'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] hold,
    input  logic [4:0]            csr_a,
    input  logic [7:0]            csr_di,
    input  logic                  csr_we,
    output logic [7:0]            csr_do,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  done
);

    localparam logic [4:0] A_DELAY  = BASE_ADDR + OFF_DELAY;
    localparam logic [4:0] A_CTRL   = BASE_ADDR + OFF_CTRL;
    localparam logic [1:0] LAST_IDX = 2'(NUM_STAGES - 1);

    logic [1:0]            state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [NUM_STAGES-1:0] rel_q, rel_d;
    logic [NUM_STAGES-1:0] sw_force_q;
    logic [NUM_STAGES-1:0] rst_out_q;
    logic [7:0]            delay_q;
    logic                  done_q;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  busy;
    logic [3:0]            force4;

    assign busy = (state_q == ST_WAIT);

    // Counting only happens in WAIT; start/abort take precedence so a
    // coincident ce never counts toward the new stage.
    assign cnt_dec = ce & busy & ~start & ~abort;

    tick_counter u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .val_i  (delay_q),
        .ce_i   (cnt_dec),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rel_d    = rel_q;
        cnt_load = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            rel_d   = '0;
        end else if (start) begin
            state_d  = ST_WAIT;
            idx_d    = 2'd0;
            rel_d    = '0;
            cnt_load = 1'b1;
        end else if (busy && ce && cnt_zero) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (idx_q == 2'(k)) rel_d[k] = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
                // idx returns to 0 so CTRL reads a clean 8'h80 in DONE
                state_d = ST_DONE;
                idx_d   = 2'd0;
            end else begin
                idx_d    = idx_q + 2'd1;
                cnt_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            rel_q      <= '0;
            done_q     <= 1'b0;
            rst_out_q  <= '1;
            delay_q    <= DFL_DELAY;
            sw_force_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rel_q     <= rel_d;
            done_q    <= (state_d == ST_DONE);
            // Output follows the released flags one clk later; hold and
            // sw_force only mask the output, never the sequence.
            rst_out_q <= ~rel_q | hold | sw_force_q;
            // A new DELAY only matters at the next counter reload.
            if (csr_we && (csr_a == A_DELAY)) delay_q <= csr_di;
            if (csr_we && (csr_a == A_CTRL))  sw_force_q <= csr_di[NUM_STAGES-1:0];
        end
    end

    always_comb begin
        force4                   = 4'd0;
        force4[NUM_STAGES-1:0]   = sw_force_q;
        csr_do                   = 8'h00;
        if (csr_a == A_DELAY) begin
            csr_do = delay_q;
        end else if (csr_a == A_CTRL) begin
            csr_do = {done_q, busy, idx_q, force4};
        end
    end

    assign rst_out = rst_out_q;
    assign done    = done_q;

endmodule
